pll_reset_seq: RTL and testbench
================================

PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
- REQ-001: Parameter RST_PULSE_CYC, default 16: number of refclk cycles pll_rst is held high per PLL reset; legal range 1..255.
- REQ-002: Parameter LOCK_STABLE_CYC, default 1024: number of consecutive synchronized-locked cycles required before the core is released; legal range 1..65535.
- REQ-003: Parameter LOCK_TIMEOUT_CYC, default 65535: maximum number of cycles waited for lock per attempt; legal range 1..65535.
- REQ-004: Parameter RETRY_MAX, default 3: number of PLL reset retries allowed after the first failed attempt before entering FAIL; legal range 0..15.
- REQ-005: refclk  in  1  sole clock; all logic is on its rising edge.
- REQ-006: rst_n  in  1  asynchronous, active-low reset.
- REQ-007: pll_locked  in  1  PLL locked status; asynchronous to refclk.
- REQ-008: relock_req  in  1  single-cycle request to force a full PLL reset sequence.
- REQ-009: pll_rst  out  1  drives the PLL rst input; active high.
- REQ-010: core_reset  out  1  reset for the core clocked by the PLL output; active high.
- REQ-011: ready  out  1  high only in state RUN.
- REQ-012: timeout_err  out  1  high only in state FAIL.
- REQ-013: loss_count  out  4  saturating count of lock losses that occur in RUN.

Function
- REQ-014: pll_locked SHALL pass through a 2-flop synchronizer to produce lk_s; all decisions use lk_s only.
- REQ-015: The FSM states SHALL be PRST, WLOCK, STABLE, RUN and FAIL, with one shared 16-bit cycle counter and a 4-bit retry counter.
- REQ-016: PRST: pll_rst=1, core_reset=1; after exactly RST_PULSE_CYC cycles in PRST -> WLOCK, counter cleared.
- REQ-017: WLOCK: pll_rst=0, core_reset=1; lk_s=1 -> STABLE with counter cleared.
- REQ-018: WLOCK timeout: after LOCK_TIMEOUT_CYC cycles without lk_s, if retry<RETRY_MAX -> retry+1 and PRST; otherwise -> FAIL.
- REQ-019: STABLE: core_reset=1; lk_s=0 at any cycle -> WLOCK with counter cleared (the timeout restarts and retry is unchanged); LOCK_STABLE_CYC consecutive cycles of lk_s=1 -> RUN.
- REQ-020: RUN: core_reset=0, ready=1; retry counter cleared on entry; lk_s=0 -> PRST with loss_count+1, saturating at 15.
- REQ-021: FAIL: pll_rst=0, core_reset=1, timeout_err=1; exit only via relock_req or rst_n.
- REQ-022: relock_req=1 in any state -> PRST next cycle, with retry cleared and counter cleared; relock_req takes priority over every other transition in the same cycle.
- REQ-023: All outputs SHALL be registered; an output change appears 1 cycle after the state transition that causes it.
- REQ-024: The counter SHALL never wrap; each comparison uses the exact parameter value.

Reset
- REQ-025: While rst_n=0: state=PRST, counters=0, loss_count=0, synchronizer=0, pll_rst=1, core_reset=1, ready=0, timeout_err=0.
- REQ-026: On rst_n deassertion, the first PRST interval SHALL last exactly RST_PULSE_CYC cycles.
- REQ-027: rst_n asserted mid-sequence SHALL abort immediately to the reset values, including from RUN and FAIL.

Configuration
- REQ-028: Macro PLL_SEQ_LOSS_COUNT_EN: when defined, loss_count operates per REQ-020; when undefined, the counter logic is omitted and loss_count is tied to 0, and all other behaviour is unchanged.

Verification
All scenarios use RST_PULSE_CYC=4, LOCK_STABLE_CYC=8, LOCK_TIMEOUT_CYC=20, RETRY_MAX=2.
- REQ-029: Nominal start: release rst_n, raise pll_locked 10 cycles later -> pll_rst high for 4 cycles; ready=1 and core_reset=0 reached 2 (synchronizer) + 8 + 1 cycles after lock.
- REQ-030: Lock never asserts -> 3 PRST pulses of 4 cycles each, separated by 20-cycle waits, then timeout_err=1 with pll_rst=0.
- REQ-031: Lock glitch: pll_locked high for 5 cycles then low during STABLE -> state returns to WLOCK, ready stays 0, and no new pll_rst pulse occurs.
- REQ-032: Lock loss in RUN, repeated 17 times -> each loss produces a 4-cycle pll_rst pulse and core_reset=1; loss_count reads 15 with the macro defined and 0 without it.
- REQ-033: relock_req in FAIL, and relock_req coincident with pll_locked falling in RUN -> PRST next cycle and retry=0; loss_count not incremented in the coincident case.
- REQ-034: rst_n pulsed low in STABLE -> all outputs take their reset values asynchronously, followed by a fresh 4-cycle PRST.

Source files
------------

// File: rtl/pll_reset_seq.sv
// pll_reset_seq: PLL reset pulse, lock qualification and core reset release on refclk.
// Define PLL_SEQ_LOSS_COUNT_EN to build the RUN lock-loss counter; otherwise loss_count is tied to 0.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   PRST   | PLL held in reset for RST_PULSE_CYC cycles
//   WLOCK  | PLL released, waiting for lock (bounded by LOCK_TIMEOUT_CYC)
//   STABLE | lock seen, qualifying LOCK_STABLE_CYC consecutive locked cycles
//   RUN    | core released, ready asserted
//   FAIL   | retries exhausted, waits for relock_req or rst_n
module pll_reset_seq #(
  parameter int unsigned RST_PULSE_CYC    = 16,
  parameter int unsigned LOCK_STABLE_CYC  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYC = 65535,
  parameter int unsigned RETRY_MAX        = 3
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       core_reset,
  output logic       ready,
  output logic       timeout_err,
  output logic [3:0] loss_count
);

  typedef enum logic [2:0] {
    PRST   = 3'd0,
    WLOCK  = 3'd1,
    STABLE = 3'd2,
    RUN    = 3'd3,
    FAIL   = 3'd4
  } state_e;

  localparam logic [15:0] PRST_LAST   = 16'(RST_PULSE_CYC - 1);
  localparam logic [15:0] TMO_LAST    = 16'(LOCK_TIMEOUT_CYC - 1);
  // The WLOCK cycle that first sees lk_s already counts as one locked cycle.
  localparam logic [15:0] STABLE_LAST = (LOCK_STABLE_CYC > 1) ? 16'(LOCK_STABLE_CYC - 2) : 16'd0;
  localparam logic [3:0]  RETRY_LIM   = 4'(RETRY_MAX);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  retry_q, retry_d;
  logic [1:0]  sync_q;
  logic        lk_s;
  logic        loss_inc;
  logic        pll_rst_q, core_reset_q, ready_q, timeout_err_q;

  assign lk_s = sync_q[1];

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pll_locked};
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PRST;
      cnt_q   <= 16'd0;
      retry_q <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    retry_d  = retry_q;
    loss_inc = 1'b0;
    if (relock_req) begin
      state_d = PRST;
      cnt_d   = 16'd0;
      retry_d = 4'd0;
    end else begin
      case (state_q)
        PRST: begin
          if (cnt_q == PRST_LAST) begin
            state_d = WLOCK;
            cnt_d   = 16'd0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        WLOCK: begin
          if (lk_s) begin
            state_d = STABLE;
            cnt_d   = 16'd0;
          end else if (cnt_q == TMO_LAST) begin
            cnt_d = 16'd0;
            if (retry_q < RETRY_LIM) begin
              retry_d = retry_q + 4'd1;
              state_d = PRST;
            end else begin
              state_d = FAIL;
            end
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        STABLE: begin
          if (!lk_s) begin
            state_d = WLOCK;
            cnt_d   = 16'd0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = RUN;
            cnt_d   = 16'd0;
            retry_d = 4'd0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        RUN: begin
          if (!lk_s) begin
            state_d  = PRST;
            cnt_d    = 16'd0;
            loss_inc = 1'b1;
          end
        end
        FAIL: begin
          state_d = FAIL;
        end
        default: begin
          state_d = PRST;
          cnt_d   = 16'd0;
          retry_d = 4'd0;
        end
      endcase
    end
  end

  // Outputs decode the registered state, so they follow a transition by one cycle.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      pll_rst_q     <= 1'b1;
      core_reset_q  <= 1'b1;
      ready_q       <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      pll_rst_q     <= (state_q == PRST);
      core_reset_q  <= (state_q != RUN);
      ready_q       <= (state_q == RUN);
      timeout_err_q <= (state_q == FAIL);
    end
  end

  assign pll_rst     = pll_rst_q;
  assign core_reset  = core_reset_q;
  assign ready       = ready_q;
  assign timeout_err = timeout_err_q;

`ifdef PLL_SEQ_LOSS_COUNT_EN
  logic [3:0] loss_q;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      loss_q <= 4'd0;
    end else if (loss_inc && (loss_q != 4'hF)) begin
      loss_q <= loss_q + 4'd1;
    end
  end

  assign loss_count = loss_q;
`else
  logic unused_loss_inc;

  assign unused_loss_inc = loss_inc;
  assign loss_count      = 4'd0;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq with RST_PULSE_CYC=4, LOCK_STABLE_CYC=8, LOCK_TIMEOUT_CYC=20, RETRY_MAX=2.
// Expected loss_count follows PLL_SEQ_LOSS_COUNT_EN when the bench is built with it.
module tb_pll_reset_seq;

  logic       refclk;
  logic       rst_n;
  logic       pll_locked;
  logic       relock_req;
  logic       pll_rst;
  logic       core_reset;
  logic       ready;
  logic       timeout_err;
  logic [3:0] loss_count;

  int n_tests = 0;
  int n_fail  = 0;

  pll_reset_seq #(
    .RST_PULSE_CYC   (4),
    .LOCK_STABLE_CYC (8),
    .LOCK_TIMEOUT_CYC(20),
    .RETRY_MAX       (2)
  ) u_dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .relock_req (relock_req),
    .pll_rst    (pll_rst),
    .core_reset (core_reset),
    .ready      (ready),
    .timeout_err(timeout_err),
    .loss_count (loss_count)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge refclk);
      #1;
    end
  endtask

  function automatic int exp_loss(input int n);
`ifdef PLL_SEQ_LOSS_COUNT_EN
    return (n > 15) ? 15 : n;
`else
    return 0;
`endif
  endfunction

  // Reset for two edges, release just after an edge (edge e0 of the new sequence).
  task automatic release_rst();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic count_pll_rst(input string tag, input int n, input int exp);
    int c;
    c = 0;
    repeat (n) begin
      tick();
      if (pll_rst === 1'b1) c++;
    end
    chk(tag, c, exp);
  endtask

  task automatic wait_ready(input string tag, input int budget, input int exp_cyc);
    int c;
    c = 0;
    while ((ready !== 1'b1) && (c < budget)) begin
      tick();
      c++;
    end
    chk(tag, c, exp_cyc);
  endtask

  // Lock held low from a PRST entry edge: pulses at 1-4, 25-28, 49-52, FAIL flag from 73.
  task automatic run_nolock(input string tag);
    logic ep, et;
    for (int i = 1; i <= 80; i++) begin
      tick();
      ep = ((i <= 4) || (i >= 25 && i <= 28) || (i >= 49 && i <= 52));
      et = (i >= 73);
      chk($sformatf("%s c%0d", tag, i), {30'd0, pll_rst, timeout_err}, {30'd0, ep, et});
    end
    chk({tag, " core_reset"}, core_reset, 1);
  endtask

  // From RUN: drop lock, expect a 4-cycle pll_rst pulse, then relock to RUN.
  task automatic lose_lock(input int k);
    int pr, cr;
    pr = 0;
    cr = 0;
    pll_locked = 1'b0;
    repeat (12) begin
      tick();
      if (pll_rst === 1'b1) pr++;
      if (core_reset === 1'b1) cr++;
    end
    chk($sformatf("loss%0d pll_rst cycles", k), pr, 4);
    chk($sformatf("loss%0d core_reset cycles", k), cr, 9);
    chk($sformatf("loss%0d loss_count", k), loss_count, exp_loss(k + 1));
    pll_locked = 1'b1;
    wait_ready($sformatf("loss%0d relock ready", k), 30, 11);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pr, rd;
    rst_n      = 1'b1;
    pll_locked = 1'b0;
    relock_req = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset pll_rst", pll_rst, 1);
    chk("reset core_reset", core_reset, 1);
    chk("reset ready", ready, 0);
    chk("reset timeout_err", timeout_err, 0);
    chk("reset loss_count", loss_count, 0);

    // Lock never asserts: three attempts then FAIL; relock from FAIL clears retry.
    release_rst();
    run_nolock("nolock");
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    run_nolock("relock_fail");

    // Lock glitch in STABLE: back to WLOCK with a fresh timeout, no pulse, no ready.
    pll_locked = 1'b0;
    release_rst();
    tick(10);
    pll_locked = 1'b1;
    tick(5);
    pll_locked = 1'b0;
    pr = 0;
    rd = 0;
    for (int i = 16; i <= 38; i++) begin
      tick();
      if (pll_rst === 1'b1) pr++;
      if (ready === 1'b1) rd++;
    end
    chk("glitch pll_rst cycles", pr, 0);
    chk("glitch ready cycles", rd, 0);
    tick();
    chk("glitch restarted timeout pulse", pll_rst, 1);

    // Nominal start.
    pll_locked = 1'b0;
    release_rst();
    count_pll_rst("start pll_rst cycles", 10, 4);
    pll_locked = 1'b1;
    tick(10);
    chk("nominal ready early", ready, 0);
    chk("nominal core_reset early", core_reset, 1);
    tick();
    chk("nominal ready", ready, 1);
    chk("nominal core_reset", core_reset, 0);
    chk("nominal pll_rst", pll_rst, 0);

    // relock_req in the same cycle RUN sees the lock loss: no loss counted.
    pll_locked = 1'b0;
    tick(2);
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    tick();
    chk("coincident pll_rst", pll_rst, 1);
    chk("coincident ready", ready, 0);
    chk("coincident loss_count", loss_count, 0);
    tick(8);
    pll_locked = 1'b1;
    wait_ready("coincident relock ready", 30, 11);

    // Seventeen lock losses in RUN; the counter saturates.
    for (int k = 0; k < 17; k++) lose_lock(k);
    chk("loss_count final", loss_count, exp_loss(17));

    // rst_n in STABLE: asynchronous reset values, then a fresh PRST pulse.
    pll_locked = 1'b0;
    tick(12);
    pll_locked = 1'b1;
    tick(5);
    chk("stable pre pll_rst", pll_rst, 0);
    chk("stable pre ready", ready, 0);
    rst_n = 1'b0;
    #1;
    chk("async rst pll_rst", pll_rst, 1);
    chk("async rst core_reset", core_reset, 1);
    chk("async rst ready", ready, 0);
    chk("async rst timeout_err", timeout_err, 0);
    chk("async rst loss_count", loss_count, 0);
    tick();
    rst_n = 1'b1;
    count_pll_rst("post rst pll_rst cycles", 10, 4);
    wait_ready("post rst ready", 30, 3);

    // rst_n in RUN aborts immediately.
    rst_n = 1'b0;
    #1;
    chk("run rst ready", ready, 0);
    chk("run rst core_reset", core_reset, 1);
    chk("run rst pll_rst", pll_rst, 1);
    tick();
    rst_n = 1'b1;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
